// File: rtl/detection_collector_pkg.sv
// Shared constants and state encoding for the detection collector slice.
package detect_pkg;

  localparam int         N_CH_DEF = 4;
  localparam int         TW_DEF   = 32;
  localparam logic [7:0] DUP_MAX  = 8'd255;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

endpackage

// File: rtl/detection_collector_if.sv
// Detector-side valid/ack handshakes plus the outgoing frame handshake.
interface detection_collector_if
  import detect_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int TW   = TW_DEF
);

  logic [N_CH-1:0]         ch_valid;
  logic [N_CH*TW-1:0]      ch_time;
  logic [N_CH-1:0]         ch_ack;
  logic                    out_valid;
  logic                    out_ack;
  logic [N_CH*TW-1:0]      out_time;
  logic [N_CH-1:0]         out_mask;
  logic [$clog2(N_CH)-1:0] out_first;
  logic                    out_timeout;
  logic [7:0]              dup_cnt;

  // Collector side
  modport master (
    input  ch_valid, ch_time, out_ack,
    output ch_ack, out_valid, out_time, out_mask, out_first, out_timeout, dup_cnt
  );

  // Detector / frame-consumer side
  modport slave (
    output ch_valid, ch_time, out_ack,
    input  ch_ack, out_valid, out_time, out_mask, out_first, out_timeout, dup_cnt
  );

endinterface

// File: rtl/detection_collector_slot.sv
// One channel's capture slot: timestamp register, captured flag and ack pulse.
module channel_capture_slot #(
  parameter int TW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid,
  input  logic [TW-1:0] ts_in,
  input  logic          en,
  input  logic          clr,
  output logic [TW-1:0] ts_q,
  output logic          captured,
  output logic          ack,
  output logic          eligible,
  output logic          dup
);

  logic ack_q;
  logic mask_q;

  // A held valid is masked while its ack is out, covering the detector's fall latency
  assign eligible = valid & ~ack_q & en;
  assign dup      = eligible & mask_q;
  assign captured = mask_q;
  assign ack      = ack_q;

  // Ack every accepted event once; first event of a frame is kept, later ones discarded
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q  <= 1'b0;
      mask_q <= 1'b0;
      ts_q   <= '0;
    end else begin
      ack_q <= eligible;
      if (clr) begin
        mask_q <= 1'b0;
        ts_q   <= '0;
      end else if (eligible && !mask_q) begin
        mask_q <= 1'b1;
        ts_q   <= ts_in;
      end
    end
  end

endmodule

// File: rtl/detection_collector.sv
// Collects per-channel detection timestamps into one frame for TDOA localisation.
module detection_collector
  import detect_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int TW   = TW_DEF,
  parameter int CW   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_tick,
  input  logic [CW-1:0]           window_len,
  detection_collector_if.master   bus
);

  localparam int IW = $clog2(N_CH);

  state_t                   state, state_nx;
  logic [N_CH-1:0]          elig, dup, mask, ack;
  logic [N_CH-1:0][TW-1:0]  ts;
  logic [CW-1:0]            win_cnt, win_len_q;
  logic                     slot_en, slot_clr, all_cap, expired, found;
  logic [IW-1:0]            first_idx, first_q;
  logic [7:0]               dup_nx, dup_q;
  logic                     timeout_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_slot
    channel_capture_slot #(.TW(TW)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .valid    (bus.ch_valid[i]),
      .ts_in    (bus.ch_time[i*TW +: TW]),
      .en       (slot_en),
      .clr      (slot_clr),
      .ts_q     (ts[i]),
      .captured (mask[i]),
      .ack      (ack[i]),
      .eligible (elig[i]),
      .dup      (dup[i])
    );
  end

  assign all_cap = &mask;
  assign expired = (win_cnt >= win_len_q);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  // Next state; completion beats window expiry in the same cycle
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (|elig)               state_nx = ST_COLLECT;
      ST_COLLECT: if (all_cap || expired)  state_nx = ST_PRESENT;
      ST_PRESENT: if (bus.out_ack)         state_nx = ST_IDLE;
      default:                             state_nx = ST_IDLE;
    endcase
  end

  // State-decoded outputs: slots are frozen while a frame is presented
  always_comb begin
    bus.out_valid = (state == ST_PRESENT);
    slot_en       = (state != ST_PRESENT);
    slot_clr      = (state == ST_PRESENT) && bus.out_ack;
  end

  // Lowest eligible channel opens the frame
  always_comb begin
    first_idx = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (elig[i] && !found) begin
        first_idx = IW'(i);
        found     = 1'b1;
      end
    end
  end

  // Saturating add of this cycle's discarded duplicates
  always_comb begin
    dup_nx = dup_q;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (dup[i] && dup_nx != DUP_MAX) dup_nx = dup_nx + 8'd1;
    end
  end

  // Window counter, frame metadata and duplicate count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_cnt   <= '0;
      win_len_q <= '0;
      first_q   <= '0;
      dup_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|elig) begin
            win_len_q <= window_len;
            win_cnt   <= '0;
            first_q   <= first_idx;
          end
        end
        ST_COLLECT: begin
          if (sample_tick && win_cnt != '1) win_cnt <= win_cnt + CW'(1);
          dup_q <= dup_nx;
          if (!all_cap && expired) timeout_q <= 1'b1;
        end
        ST_PRESENT: begin
          if (bus.out_ack) begin
            dup_q     <= '0;
            first_q   <= '0;
            timeout_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ch_ack      = ack;
  assign bus.out_time    = ts;
  assign bus.out_mask    = mask;
  assign bus.out_first   = first_q;
  assign bus.out_timeout = timeout_q;
  assign bus.dup_cnt     = dup_q;

endmodule

// File: doc/detection_collector.md
Name: detection_collector

Overview:
- Gathers threshold-detector events from N_CH microphone channels into one timestamp frame for TDOA localisation downstream (CPU / UART packer).
- Consumes each channel's valid/ack detect_time handshake and opens a collection window on the first detection.
- Closes the frame when all channels have reported or the window expires, then presents the frame with its own valid/ack handshake.

Parameters:
- N_CH, 4, number of detector channels.
- TW, 32, timestamp width in bits.
- CW, 32, window counter width in bits.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset (low = reset).
- sample_tick  in  1  one-cycle pulse per filter output sample; the time base for the window.
- window_len  in  CW  window length in sample_ticks; sampled when the window opens.
- ch_valid  in  N_CH  per-channel detection valid, held by the detector until acked.
- ch_time  in  N_CH*TW  per-channel detect_time; channel i occupies bits [i*TW +: TW].
- ch_ack  out  N_CH  per-channel ack, registered one-cycle pulse.
- out_valid  out  1  frame valid; held until out_ack.
- out_ack  in  1  frame consumer ack.
- out_time  out  N_CH*TW  captured timestamps; uncaptured slots read 0.
- out_mask  out  N_CH  bit i set = channel i captured.
- out_first  out  $clog2(N_CH)  index of the first-captured channel; ties go to the lowest index.
- out_timeout  out  1  frame closed by window expiry with out_mask not all ones.
- dup_cnt  out  8  saturating count of duplicate detections discarded in the current frame.

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs 0; state IDLE.
  - Captured registers, window counter and window_len copy all cleared.
- Capture eligibility: channel i is eligible in a cycle when ch_valid[i] & ~ch_ack[i].
  - The ack_reg masking covers the detector's one-cycle valid fall latency, so no double capture.
- Acking: for every eligible channel accepted in cycle k (capture or discard), ch_ack[i]=1 in cycle k+1 only.
- States IDLE, COLLECT, PRESENT.
- IDLE:
  - If any channel is eligible, capture all eligible channels in the same cycle: store time, set mask bit.
  - Set out_first to the lowest eligible index.
  - Load win_len_q from window_len, clear win_cnt, go to COLLECT.
- COLLECT, per eligible channel:
  - Mask bit clear: capture time, set mask bit.
  - Mask bit set: discard, ack, increment dup_cnt (saturates at 255).
- COLLECT, window counting: win_cnt increments on sample_tick.
- COLLECT, exit: evaluated on registered state after captures.
  - mask all ones -> PRESENT, timeout=0.
  - Else win_cnt >= win_len_q -> PRESENT, timeout=1.
  - All-captured has priority over expiry in the same cycle.
  - window_len=0: the frame closes the cycle after opening, with the channels captured so far.
- PRESENT:
  - out_valid=1; out_time, out_mask, out_first, out_timeout and dup_cnt are stable.
  - No channel is eligible or acked; detector valids stay pending.
  - On out_valid & out_ack: clear out_valid, mask, times and dup_cnt next cycle, go to IDLE.
  - Pending ch_valid is captured in IDLE on the following cycle at the earliest.
- Outputs: registered; out_time/out_mask reflect captured registers directly.
- Latency:
  - First ch_valid rising to ch_ack: 1 cycle.
  - Last channel captured to out_valid: 1 cycle.
- Width rules:
  - win_cnt saturates at all ones; no wrap.
  - Timestamps are passed unmodified; no subtraction in this block.
- sample_tick in IDLE or PRESENT: ignored.
- Reset mid-frame: immediate abort, all state cleared; detectors that are not acked keep valid high and are captured after reset release.

Decomposition:
- Shared package detect_pkg:
  - constants N_CH_DEF=4, TW_DEF=32.
  - state encoding localparams ST_IDLE=2'd0, ST_COLLECT=2'd1, ST_PRESENT=2'd2.
  - DUP_MAX=8'd255.
- One sub-module, channel_capture_slot (per channel, instantiated N_CH times):
  - holds time register, mask bit and ack_reg.
  - inputs: eligible-enable, clear.
  - outputs: captured, duplicate pulse.
- The top level holds the FSM, window counter, priority encoder for out_first and dup_cnt.

Test Plan:
- All channels, one cycle: ch_valid=4'b1111 in one cycle, times 100/101/102/103 -> ch_ack=4'b1111 next cycle; out_valid 1 cycle later; out_mask=4'b1111, out_first=0, out_timeout=0.
- Staggered arrival, window_len=10: ch2 t=500, then ch0 t=503 after 3 ticks, ch3 and ch1 after 6 ticks -> out_first=2, mask full, timeout=0, times correct per slot.
- Timeout, window_len=5: only ch1 fires (t=42) -> after the 5th sample_tick out_valid=1, out_mask=4'b0010, out_timeout=1, other slots 0.
- Duplicate detection: ch0 fires twice during COLLECT (t=10, then t=20), others complete -> slot0=10, dup_cnt=1, both ch0 events acked exactly once each.
- Backpressure: hold out_ack=0 for 20 cycles while ch3 raises valid -> out_valid and frame stay stable, no ch_ack; after the out_ack cycle, the next frame opens with out_first=3.
- Async reset mid-COLLECT: assert rst low between clock edges -> all outputs 0 immediately; with ch_valid still high after release, capture resumes with ack 1 cycle later.
